inverse_sub_bytes_iter: RTL and testbench
=========================================

INVERSE_SUB_BYTES_ITER -- requirements
Module: inverse_sub_bytes_iter

Interface
REQ-001 SHALL have parameter LANES, default 4: S-box lookups per cycle; legal values 1, 2, 4, 8, 16.
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-003 SHALL have port n_rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port invDataIn, input, 128 bits: cipher state from InvShiftRows, byte 0 = bits [127:120].
REQ-005 SHALL have port inValid, input, 1 bit: invDataIn is valid.
REQ-006 SHALL have port inReady, output, 1 bit: block can accept a new state.
REQ-007 SHALL have port invDataOut, output, 128 bits: InvSubBytes result for AddRoundKey/InvMixColumns.
REQ-008 SHALL have port outValid, output, 1 bit: invDataOut holds a complete result.
REQ-009 SHALL have port outReady, input, 1 bit: consumer accepts invDataOut.
REQ-010 SHALL have port busy, output, 1 bit: high in SUB or DONE.

Function
REQ-011 SHALL implement FSM states IDLE, SUB, DONE.
REQ-012 IDLE: inReady=1; on inValid&&inReady, latch invDataIn into state register, clear byte counter to 0, go to SUB.
REQ-013 SUB: each cycle replace bytes [cnt .. cnt+LANES-1] with InvSbox(byte); cnt += LANES.
REQ-014 SUB: after the cycle processing bytes 16-LANES..15, go to DONE; result latency = 16/LANES cycles from the accept edge to outValid high.
REQ-015 DONE: outValid=1; invDataOut and outValid held stable until outValid&&outReady, then go to IDLE.
REQ-016 inReady SHALL be 0 in SUB and DONE; inValid in those states is ignored and no data is latched.
REQ-017 A new block is accepted no earlier than the cycle after the output handshake (no same-cycle pass-through).
REQ-018 invDataOut SHALL always drive the state register; its value is defined only while outValid=1.
REQ-019 Byte counter width SHALL be 5 bits; it never exceeds 16; no wrap occurs.
REQ-020 An illegal state encoding SHALL return to IDLE on the next edge.

Reset
REQ-021 n_rst low SHALL immediately force: state IDLE, cnt 0, invDataOut 128'h0, outValid 0, busy 0, inReady 1.
REQ-022 Reset asserted during SUB or DONE SHALL discard the in-flight block with no output handshake.
REQ-023 After n_rst deasserts, the first rising edge with inValid=1 SHALL be a legal accept.

Structure
REQ-024 Shared package aes_pkg SHALL hold AES_BLOCK_W=128, AES_BYTES=16, and the FSM state enum.
REQ-025 One sub-module inv_sbox (combinational 8-bit in / 8-bit out, 256-entry inverse S-box table) SHALL be instantiated LANES times.
REQ-026 All registers SHALL be in one always_ff on clk/negedge n_rst; next-state logic SHALL be in always_comb.

Verification (LANES=4 unless stated)
REQ-027 Reset: n_rst=0 mid-stream -> invDataOut=0, outValid=0, inReady=1, busy=0 with no clock edge.
REQ-028 invDataIn=128'h6363...63 (all bytes) -> outValid after 4 cycles, invDataOut=128'h0; invDataIn=128'h0 -> 128'h5252...52.
REQ-029 invDataIn=128'h637CFF0153ED637CFF0153ED637CFF01 -> invDataOut=128'h00017D09505300017D09505300017D09; repeat with LANES=1 (latency 16) and LANES=16 (latency 1): same value.
REQ-030 Backpressure: outReady=0 for 3 cycles in DONE, with inValid=1 and a different invDataIn -> invDataOut and outValid stable, inReady=0; outReady=1 -> IDLE the next cycle, then the new block is accepted.
REQ-031 Reset pulse during the second SUB cycle -> no outValid; next block 128'h00...00 -> 128'h52...52 after 4 cycles.
REQ-032 Back-to-back: inValid=1 and outReady=1 held continuously -> one result every 6 cycles, no lost or duplicated blocks over 8 random blocks checked against a reference model.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants and the FSM state type for the iterative InvSubBytes engine.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_BYTES   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } isb_state_e;

endpackage

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box: one byte in, one byte out, 256-entry table.
module inv_sbox (
    input  logic [7:0] sbox_in,
    output logic [7:0] sbox_out
);

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign sbox_out = INV_SBOX[sbox_in];

endmodule

// File: rtl/inverse_sub_bytes_iter.sv
// Iterative AES InvSubBytes: substitutes LANES bytes of the latched state per cycle,
// then presents the full 128-bit result under a valid/ready handshake.
import aes_pkg::*;

module inverse_sub_bytes_iter #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic [127:0] invDataIn,
    input  logic         inValid,
    output logic         inReady,
    output logic [127:0] invDataOut,
    output logic         outValid,
    input  logic         outReady,
    output logic         busy
);

    isb_state_e              state_q, state_d;
    logic [4:0]              cnt_q, cnt_d;
    logic [AES_BLOCK_W-1:0]  data_q, data_d;
    logic [AES_BLOCK_W-1:0]  sub_data;

    logic [7:0] sbox_in  [LANES];
    logic [7:0] sbox_out [LANES];
    logic [6:0] lane_pos [LANES];

    // Byte 0 lives in the top bits, so byte k sits at bit offset 8*(15-k).
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [3:0] byte_idx;
        assign byte_idx    = cnt_q[3:0] + 4'(l);
        assign lane_pos[l] = {4'd15 - byte_idx, 3'b000};
        assign sbox_in[l]  = data_q[lane_pos[l] +: 8];

        inv_sbox u_inv_sbox (
            .sbox_in  (sbox_in[l]),
            .sbox_out (sbox_out[l])
        );
    end

    always_comb begin
        sub_data = data_q;
        for (int l = 0; l < LANES; l++) begin
            sub_data[lane_pos[l] +: 8] = sbox_out[l];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (inValid) begin
                    data_d  = invDataIn;
                    cnt_d   = 5'd0;
                    state_d = SUB;
                end
            end
            SUB: begin
                data_d = sub_data;
                cnt_d  = cnt_q + 5'(LANES);
                if (cnt_q == 5'(AES_BYTES - LANES)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (outReady) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    // Handshake outputs decode straight from the state flop so reset takes effect without a clock.
    assign inReady    = (state_q == IDLE);
    assign outValid   = (state_q == DONE);
    assign busy       = (state_q == SUB) || (state_q == DONE);
    assign invDataOut = data_q;

endmodule

// File: tb/tb_inverse_sub_bytes_iter.sv
// Self-checking bench for inverse_sub_bytes_iter: directed vector table for LANES 1/4/16,
// plus reset, backpressure and back-to-back sequences against an independently derived model.
module tb_inverse_sub_bytes_iter;

    logic         clk;
    logic         n_rst;
    logic [127:0] data_in;
    logic         out_ready;
    logic         iv   [3];
    logic         ir   [3];
    logic         ov   [3];
    logic         bz   [3];
    logic [127:0] dout [3];

    int checks;
    int failures;
    logic [7:0] ref_inv [256];

    localparam logic [127:0] PAT_IN  = 128'h637CFF0153ED637CFF0153ED637CFF01;
    localparam logic [127:0] PAT_EXP = 128'h00017D09505300017D09505300017D09;
    localparam logic [127:0] ALL_63  = {16{8'h63}};
    localparam logic [127:0] ALL_52  = {16{8'h52}};

    typedef struct {
        int           sel;
        logic [127:0] din;
        logic [127:0] exp;
        int           lat;
        string        name;
    } vec_t;

    vec_t vecs [6];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    inverse_sub_bytes_iter #(.LANES(4)) dut4 (
        .clk(clk), .n_rst(n_rst), .invDataIn(data_in), .inValid(iv[0]), .inReady(ir[0]),
        .invDataOut(dout[0]), .outValid(ov[0]), .outReady(out_ready), .busy(bz[0])
    );
    inverse_sub_bytes_iter #(.LANES(1)) dut1 (
        .clk(clk), .n_rst(n_rst), .invDataIn(data_in), .inValid(iv[1]), .inReady(ir[1]),
        .invDataOut(dout[1]), .outValid(ov[1]), .outReady(out_ready), .busy(bz[1])
    );
    inverse_sub_bytes_iter #(.LANES(16)) dut16 (
        .clk(clk), .n_rst(n_rst), .invDataIn(data_in), .inValid(iv[2]), .inReady(ir[2]),
        .invDataOut(dout[2]), .outValid(ov[2]), .outReady(out_ready), .busy(bz[2])
    );

    // Reference inverse table built by inverting the forward S-box (GF(2^8) inverse + affine map).
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic buildModel();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(x), 8'(b)) == 8'h01) inv = 8'(b);
            end
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            ref_inv[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] refInvSubBytes(input logic [127:0] d);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) begin
            r[8*k +: 8] = ref_inv[d[8*k +: 8]];
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%b required=%b", name, actual, expected);
        end
    endtask

    task automatic checkInt(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    // Called #1 after the accept edge; counts edges until outValid, -1 on timeout.
    task automatic waitValid(input int sel, output int lat);
        lat = 0;
        while (!ov[sel] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!ov[sel]) lat = -1;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic applyStimulus(input int sel, input logic [127:0] din, input logic [127:0] exp,
                                 input int expLat, input string name);
        int lat;
        @(negedge clk);
        checkBit({name, "_inReady"}, ir[sel], 1'b1);
        data_in = din;
        iv[sel] = 1'b1;
        @(posedge clk); #1;
        iv[sel] = 1'b0;
        waitValid(sel, lat);
        checkInt({name, "_latency"}, lat, expLat);
        checkOutput({name, "_data"}, dout[sel], exp);
        handshake();
        checkBit({name, "_released"}, ov[sel], 1'b0);
    endtask

    initial begin
        int lat;
        int inIdx, outIdx, lastHs, cyc;
        logic acc, seen;
        logic [127:0] blocks [8];

        checks = 0; failures = 0;
        n_rst = 1'b0; data_in = '0; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) iv[i] = 1'b0;
        buildModel();

        vecs[0] = '{0, ALL_63,  128'h0,  4,  "l4_all63"};
        vecs[1] = '{0, 128'h0,  ALL_52,  4,  "l4_zero"};
        vecs[2] = '{0, PAT_IN,  PAT_EXP, 4,  "l4_pattern"};
        vecs[3] = '{1, PAT_IN,  PAT_EXP, 16, "l1_pattern"};
        vecs[4] = '{2, PAT_IN,  PAT_EXP, 1,  "l16_pattern"};
        vecs[5] = '{2, 128'h0,  ALL_52,  1,  "l16_zero"};

        #12;
        checkOutput("rst_dout", dout[0], 128'h0);
        checkBit("rst_outValid", ov[0], 1'b0);
        checkBit("rst_inReady", ir[0], 1'b1);
        checkBit("rst_busy", bz[0], 1'b0);
        @(negedge clk);
        n_rst = 1'b1;

        for (int v = 0; v < 6; v++) begin
            applyStimulus(vecs[v].sel, vecs[v].din, vecs[v].exp, vecs[v].lat, vecs[v].name);
        end

        // Asynchronous reset in the second SUB cycle must drop the block and clear outputs at once.
        @(negedge clk);
        data_in = PAT_IN; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        @(posedge clk); #3;
        checkBit("midrst_busy_before", bz[0], 1'b1);
        n_rst = 1'b0;
        #1;
        checkOutput("midrst_dout", dout[0], 128'h0);
        checkBit("midrst_outValid", ov[0], 1'b0);
        checkBit("midrst_inReady", ir[0], 1'b1);
        checkBit("midrst_busy", bz[0], 1'b0);
        @(negedge clk);
        n_rst = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            seen = seen | ov[0];
        end
        checkBit("midrst_no_outValid", seen, 1'b0);
        applyStimulus(0, 128'h0, ALL_52, 4, "post_rst_zero");

        // Backpressure: result held while outReady is low, competing input ignored.
        @(negedge clk);
        data_in = PAT_IN; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        checkBit("bp_busy_sub", bz[0], 1'b1);
        checkBit("bp_inReady_sub", ir[0], 1'b0);
        waitValid(0, lat);
        checkInt("bp_latency", lat, 4);
        data_in = 128'h0; iv[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("bp_hold%0d_data", k), dout[0], PAT_EXP);
            checkBit($sformatf("bp_hold%0d_outValid", k), ov[0], 1'b1);
            checkBit($sformatf("bp_hold%0d_inReady", k), ir[0], 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkBit("bp_rel_outValid", ov[0], 1'b0);
        checkBit("bp_rel_inReady", ir[0], 1'b1);
        @(posedge clk); #1;
        iv[0] = 1'b0;
        checkBit("bp_accept_busy", bz[0], 1'b1);
        waitValid(0, lat);
        checkInt("bp_next_latency", lat, 4);
        checkOutput("bp_next_data", dout[0], ALL_52);
        handshake();

        // Back-to-back with inValid and outReady held high: one result every 6 cycles.
        for (int b = 0; b < 8; b++) begin
            blocks[b] = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        inIdx = 0; outIdx = 0; lastHs = -1; cyc = 0;
        @(negedge clk);
        data_in = blocks[0]; iv[0] = 1'b1; out_ready = 1'b1;
        while (outIdx < 8 && cyc < 200) begin
            acc = ir[0] && iv[0];
            if (ov[0]) begin
                checkOutput($sformatf("b2b_blk%0d", outIdx), dout[0], refInvSubBytes(blocks[outIdx]));
                if (lastHs >= 0) checkInt($sformatf("b2b_gap%0d", outIdx), cyc - lastHs, 6);
                lastHs = cyc;
                outIdx++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                inIdx++;
                if (inIdx < 8) data_in = blocks[inIdx];
                else iv[0] = 1'b0;
            end
        end
        iv[0] = 1'b0; out_ready = 1'b0;
        checkInt("b2b_count", outIdx, 8);
        checkInt("b2b_accepted", inIdx, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
